// File: rtl/animation_speed_counter.sv
// Animation speed counter: per-level terminal-count timer driving a frame index,
// with deferred level changes so a period never shortens or stretches mid-count.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; count held, level changes apply at once
// S_RUN   | counting; level changes wait for the next wrap
// S_PAUSE | count, frame and level frozen until pause is released
module animation_speed_counter #(
  parameter int unsigned          DATAWIDTH = 24,
  parameter logic [DATAWIDTH-1:0] TERM0     = 24'hFFFFFF,
  parameter logic [DATAWIDTH-1:0] TERM1     = 24'hBFFFFF,
  parameter logic [DATAWIDTH-1:0] TERM2     = 24'h7FFFFF,
  parameter logic [DATAWIDTH-1:0] TERM3     = 24'h3FFFFF
) (
  input  logic                 CC_ANIMCOUNTER_CLOCK_50,
  input  logic                 CC_ANIMCOUNTER_RESET_InHigh,
  input  logic                 CC_ANIMCOUNTER_Start_InLow,
  input  logic                 CC_ANIMCOUNTER_Pause_InHigh,
  input  logic                 CC_ANIMCOUNTER_NivelUp_InLow,
  input  logic                 CC_ANIMCOUNTER_NivelDown_InLow,
  output logic [DATAWIDTH-1:0] CC_ANIMCOUNTER_data_OutBUS,
  output logic [1:0]           CC_ANIMCOUNTER_Nivel_Out,
  output logic                 CC_ANIMCOUNTER_T0_OutLow,
  output logic [2:0]           CC_ANIMCOUNTER_Frame_OutBUS,
  output logic                 CC_ANIMCOUNTER_Run_OutHigh
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic [1:0]           level_q, level_d;
  logic [1:0]           pend_q, pend_d;
  logic [2:0]           frame_q, frame_d;
  logic                 t0_q, t0_d;
  logic                 advance;
  logic                 wrap;

  function automatic logic [DATAWIDTH-1:0] term_of(input logic [1:0] lvl);
    case (lvl)
      2'd0:    term_of = TERM0;
      2'd1:    term_of = TERM1;
      2'd2:    term_of = TERM2;
      default: term_of = TERM3;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!CC_ANIMCOUNTER_Start_InLow) state_d = S_RUN;
      S_RUN:   if (CC_ANIMCOUNTER_Pause_InHigh) state_d = S_PAUSE;
      S_PAUSE: if (!CC_ANIMCOUNTER_Pause_InHigh) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Up and down together cancel; both ends saturate.
  always_comb begin
    pend_d = pend_q;
    if (!CC_ANIMCOUNTER_NivelUp_InLow && CC_ANIMCOUNTER_NivelDown_InLow) begin
      pend_d = (pend_q == 2'd3) ? 2'd3 : pend_q + 2'd1;
    end else if (CC_ANIMCOUNTER_NivelUp_InLow && !CC_ANIMCOUNTER_NivelDown_InLow) begin
      pend_d = (pend_q == 2'd0) ? 2'd0 : pend_q - 2'd1;
    end
  end

  // The count only moves on cycles that both start and end in RUN, so entering
  // or leaving PAUSE never consumes a count step.
  always_comb begin
    advance = (state_q == S_RUN) && (state_d == S_RUN);
    wrap    = advance && (count_q == term_of(level_q));
    count_d = count_q;
    frame_d = frame_q;
    level_d = level_q;
    if (state_q == S_IDLE) begin
      level_d = pend_d;
    end
    if (wrap) begin
      count_d = '0;
      frame_d = frame_q + 3'd1;
      level_d = pend_d;
    end else if (advance) begin
      count_d = count_q + DATAWIDTH'(1);
    end
    // Tick is decoded from next-state values so the registered tick lines up
    // with the registered count it describes.
    t0_d = !((state_d == S_RUN) && (count_d == term_of(level_d)));
  end

  always_ff @(posedge CC_ANIMCOUNTER_CLOCK_50) begin
    if (CC_ANIMCOUNTER_RESET_InHigh) begin
      state_q <= S_IDLE;
      count_q <= '0;
      level_q <= 2'd0;
      pend_q  <= 2'd0;
      frame_q <= 3'd0;
      t0_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      t0_q    <= t0_d;
    end
  end

  assign CC_ANIMCOUNTER_data_OutBUS  = count_q;
  assign CC_ANIMCOUNTER_Nivel_Out    = level_q;
  assign CC_ANIMCOUNTER_T0_OutLow    = t0_q;
  assign CC_ANIMCOUNTER_Frame_OutBUS = frame_q;
  assign CC_ANIMCOUNTER_Run_OutHigh  = (state_q == S_RUN);

endmodule

// File: tb/tb_animation_speed_counter.sv
// Scenario bench for animation_speed_counter with a 4-bit count and small
// terminal counts so whole periods fit in a few cycles.
module tb_animation_speed_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       pause = 1'b0;
  logic       up_n = 1'b1;
  logic       dn_n = 1'b1;
  logic [3:0] data;
  logic [1:0] nivel;
  logic       t0_n;
  logic [2:0] frame;
  logic       run;

  typedef struct packed {
    logic [3:0] cnt;
    logic [1:0] lvl;
    logic       t0;
    logic [2:0] frm;
    logic       run;
  } obs_t;

  typedef struct {
    logic rst, start_n, up_n, dn_n, pause;
    obs_t e;
  } step_t;

  step_t plan[$];
  obs_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  animation_speed_counter #(
    .DATAWIDTH(4), .TERM0(4'd15), .TERM1(4'd11), .TERM2(4'd7), .TERM3(4'd3)
  ) dut (
    .CC_ANIMCOUNTER_CLOCK_50       (clk),
    .CC_ANIMCOUNTER_RESET_InHigh   (rst),
    .CC_ANIMCOUNTER_Start_InLow    (start_n),
    .CC_ANIMCOUNTER_Pause_InHigh   (pause),
    .CC_ANIMCOUNTER_NivelUp_InLow  (up_n),
    .CC_ANIMCOUNTER_NivelDown_InLow(dn_n),
    .CC_ANIMCOUNTER_data_OutBUS    (data),
    .CC_ANIMCOUNTER_Nivel_Out      (nivel),
    .CC_ANIMCOUNTER_T0_OutLow      (t0_n),
    .CC_ANIMCOUNTER_Frame_OutBUS   (frame),
    .CC_ANIMCOUNTER_Run_OutHigh    (run)
  );

  always #5 clk = ~clk;

  // One planned cycle: inputs applied before the edge, outputs expected after it.
  function automatic void add(input int r, input int s, input int u, input int d,
                              input int p, input int c, input int l, input int t,
                              input int f, input int rn);
    step_t st;
    st.rst     = 1'(r);
    st.start_n = 1'(s);
    st.up_n    = 1'(u);
    st.dn_n    = 1'(d);
    st.pause   = 1'(p);
    st.e.cnt   = 4'(c);
    st.e.lvl   = 2'(l);
    st.e.t0    = 1'(t);
    st.e.frm   = 3'(f);
    st.e.run   = 1'(rn);
    plan.push_back(st);
  endfunction

  task automatic drive_next(output obs_t got);
    step_t st;
    st      = plan.pop_front();
    rst     = st.rst;
    start_n = st.start_n;
    up_n    = st.up_n;
    dn_n    = st.dn_n;
    pause   = st.pause;
    sb.push_back(st.e);
    @(posedge clk);
    #1;
    got = '{cnt: data, lvl: nivel, t0: t0_n, frm: frame, run: run};
  endtask

  task automatic test_reset();
    obs_t got, exp;
    int   i = 0;
    add(1, 0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp)  begin
        n_fail++;
        $display("FAIL reset step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  // Start held low the whole time: it must be ignored once running.
  task automatic test_start_count();
    obs_t got, exp;
    int   i = 0;
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 1);
    for (int k = 1; k <= 15; k++) add(0, 0, 1, 1, 0,  k, 0, (k == 15) ? 0 : 1, 0, 1);
    add(0, 0, 1, 1, 0,  0, 0, 1, 1, 1);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL start_count step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  task automatic test_level_defer();
    obs_t got, exp;
    int   i = 0;
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 1, 0,  k, 0, 1, 1, 1);
    add(0, 1, 0, 1, 0,  6, 0, 1, 1, 1);
    for (int k = 7; k <= 15; k++) add(0, 1, 1, 1, 0,  k, 0, (k == 15) ? 0 : 1, 1, 1);
    add(0, 1, 1, 1, 0,  0, 1, 1, 2, 1);
    for (int k = 1; k <= 11; k++) add(0, 1, 1, 1, 0,  k, 1, (k == 11) ? 0 : 1, 2, 1);
    add(0, 1, 1, 1, 0,  0, 1, 1, 3, 1);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL level_defer step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  task automatic test_pause();
    obs_t got, exp;
    int   i = 0;
    add(1, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 1);
    for (int k = 1; k <= 9; k++) add(0, 1, 1, 1, 0,  k, 0, 1, 0, 1);
    for (int k = 0; k < 20; k++) add(0, 1, 1, 1, 1,  9, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  9, 0, 1, 0, 1);
    for (int k = 10; k <= 15; k++) add(0, 1, 1, 1, 0,  k, 0, (k == 15) ? 0 : 1, 0, 1);
    // Pause on the terminal cycle; a level request while paused waits for the wrap.
    add(0, 1, 1, 1, 1,  15, 0, 1, 0, 0);
    add(0, 1, 0, 1, 1,  15, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1,  15, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  15, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0,  0, 1, 1, 1, 1);
    for (int k = 1; k <= 11; k++) add(0, 1, 1, 1, 0,  k, 1, (k == 11) ? 0 : 1, 1, 1);
    add(0, 1, 1, 1, 0,  0, 1, 1, 2, 1);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pause step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  // In IDLE a request becomes active on the same edge it is sampled.
  task automatic test_saturation();
    obs_t got, exp;
    int   i = 0;
    add(1, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0,  0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0,  0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 0,  0, 2, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 1, 0, 1, 0,  0, 3, 1, 0, 0);
      add(0, 1, 1, 1, 0,  0, 3, 1, 0, 0);
    end
    add(0, 1, 0, 0, 0,  0, 3, 1, 0, 0);
    add(0, 1, 1, 0, 0,  0, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 2, 1, 0, 0);
    add(0, 1, 1, 0, 0,  0, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0,  0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0,  0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0,  0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 0,  0, 2, 1, 0, 0);
    add(0, 1, 0, 1, 0,  0, 3, 1, 0, 0);
    add(0, 1, 0, 0, 0,  0, 3, 1, 0, 0);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL saturation step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  task automatic test_frame_wrap();
    obs_t got, exp;
    int   i = 0;
    add(0, 0, 1, 1, 0,  0, 3, 1, 0, 1);
    for (int w = 1; w <= 8; w++) begin
      for (int k = 1; k <= 3; k++) add(0, 0, 1, 1, 0,  k, 3, (k == 3) ? 0 : 1, w - 1, 1);
      add(0, 0, 1, 1, 0,  0, 3, 1, w % 8, 1);
    end
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL frame_wrap step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t got, exp;
    int   i = 0;
    for (int k = 1; k <= 3; k++) add(0, 1, 1, 1, 0,  k, 3, (k == 3) ? 0 : 1, 0, 1);
    add(0, 1, 1, 1, 0,  0, 3, 1, 1, 1);
    add(0, 1, 1, 1, 0,  1, 3, 1, 1, 1);
    add(0, 1, 1, 1, 0,  2, 3, 1, 1, 1);
    add(1, 0, 0, 1, 1,  0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 1);
    for (int k = 1; k <= 6; k++) add(0, 1, 1, 1, 0,  k, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0,  0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0,  0, 0, 1, 0, 1);
    add(0, 1, 1, 1, 0,  1, 0, 1, 0, 1);
    add(0, 1, 1, 1, 1,  1, 0, 1, 0, 0);
    add(1, 1, 1, 1, 1,  0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1,  0, 0, 1, 0, 0);
    while (plan.size() > 0) begin
      drive_next(got);
      exp = sb.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_run step %0d: got cnt=%0d lvl=%0d t0=%b frm=%0d run=%b, want cnt=%0d lvl=%0d t0=%b frm=%0d run=%b",
                 i, got.cnt, got.lvl, got.t0, got.frm, got.run, exp.cnt, exp.lvl, exp.t0, exp.frm, exp.run);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_level_defer();
    test_pause();
    test_saturation();
    test_frame_wrap();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
